// File: rtl/uart_tx.sv
// uart_tx : serial UART transmitter (8N1, optional even parity).
//
// Bytes arrive over a valid/ready handshake into a one-entry holding
// register. The FSM drains that register into a shift register and sends
// start bit, eight data bits LSB first, an optional parity bit, and a stop
// bit. If the holding register is refilled before the stop bit ends, the
// next start bit follows with no idle gap.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> even parity bit after D7, 11-bit frame
//   undefined -> plain 8N1, 10-bit frame
//
// Parameters:
//   CLOCK_RATE   clk_tx frequency in Hz
//   BAUD_RATE    line bit rate; BAUD_DIV = round(CLOCK_RATE/BAUD_RATE) >= 2
//
// Ports:
//   clk_tx        in   transmit clock, rising edge
//   rst_n_clk_tx  in   synchronous active-low reset
//   tx_data       in   byte to send
//   tx_data_vld   in   tx_data is valid
//   tx_data_rdy   out  holding register empty (registered)
//   txd_tx        out  serial line, idle high (registered)
//   tx_busy       out  frame in progress or holding register full

module uart_tx #(
   parameter int CLOCK_RATE = 125_000_000,
   parameter int BAUD_RATE  = 115_200
) (
   input  logic       clk_tx,
   input  logic       rst_n_clk_tx,
   input  logic [7:0] tx_data,
   input  logic       tx_data_vld,
   output logic       tx_data_rdy,
   output logic       txd_tx,
   output logic       tx_busy
);

   localparam int BAUD_DIV = (CLOCK_RATE + BAUD_RATE / 2) / BAUD_RATE;
   localparam int CNT_W    = (BAUD_DIV < 2) ? 1 : $clog2(BAUD_DIV);

   generate
      if (BAUD_DIV < 2) begin : g_baud_div_check
         $error("uart_tx: BAUD_DIV must be at least 2");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_baud_cnt;
   logic [2:0]         r_bit_idx;
   logic [7:0]         r_shift;
   logic [7:0]         r_hold;
   logic               r_hold_full;
   logic               r_rdy;
   logic               r_txd;

   logic               w_bit_end;
   logic               w_load;
   logic               w_hold_wr;
   logic               w_hold_full_nxt;
   logic               w_txd_nxt;

   assign w_bit_end = (r_baud_cnt == CNT_W'(BAUD_DIV - 1));
   assign w_hold_wr = tx_data_vld && r_rdy;

   // Next state, line value and drain request
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_txd_nxt   = 1'b1;
      case (r_state)
         S_IDLE: begin
            w_txd_nxt = 1'b1;
            if (r_hold_full) begin
               w_load      = 1'b1;
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            w_txd_nxt = 1'b0;
            if (w_bit_end) w_state_nxt = S_DATA;
         end
         S_DATA: begin
            w_txd_nxt = r_shift[r_bit_idx];
            if (w_bit_end && (r_bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
               w_state_nxt = S_PARITY;
`else
               w_state_nxt = S_STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            w_txd_nxt = ^r_shift;
            if (w_bit_end) w_state_nxt = S_STOP;
         end
`endif
         S_STOP: begin
            w_txd_nxt = 1'b1;
            if (w_bit_end) begin
               // A byte waiting in the holding register starts the next
               // frame straight from the stop bit, keeping frames contiguous.
               if (r_hold_full) begin
                  w_load      = 1'b1;
                  w_state_nxt = S_START;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Holding register occupancy; write and drain are mutually exclusive
   always_comb begin
      w_hold_full_nxt = r_hold_full;
      if (w_load)         w_hold_full_nxt = 1'b0;
      else if (w_hold_wr) w_hold_full_nxt = 1'b1;
   end

   always_ff @(posedge clk_tx) begin
      if (!rst_n_clk_tx) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Baud counter restarts on every state entry and wraps between data bits
   always_ff @(posedge clk_tx) begin
      if (!rst_n_clk_tx) begin
         r_baud_cnt <= '0;
      end else if ((r_state == S_IDLE) || (w_state_nxt != r_state) || w_bit_end) begin
         r_baud_cnt <= '0;
      end else begin
         r_baud_cnt <= r_baud_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk_tx) begin
      if (!rst_n_clk_tx) begin
         r_bit_idx <= 3'd0;
      end else if (r_state != S_DATA) begin
         r_bit_idx <= 3'd0;
      end else if (w_bit_end) begin
         r_bit_idx <= r_bit_idx + 3'd1;
      end
   end

   always_ff @(posedge clk_tx) begin
      if (!rst_n_clk_tx) begin
         r_hold_full <= 1'b0;
         r_rdy       <= 1'b1;
         r_txd       <= 1'b1;
      end else begin
         r_hold_full <= w_hold_full_nxt;
         r_rdy       <= !w_hold_full_nxt;
         r_txd       <= w_txd_nxt;
      end
   end

   // Data registers carry no reset; occupancy is tracked by r_hold_full
   always_ff @(posedge clk_tx) begin
      if (w_hold_wr) r_hold  <= tx_data;
      if (w_load)    r_shift <= r_hold;
   end

   assign tx_data_rdy = r_rdy;
   assign txd_tx      = r_txd;
   assign tx_busy     = (r_state != S_IDLE) || r_hold_full;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx : directed bench for uart_tx.
// Instance u_a uses default rates (1085 cycles/bit); u_b uses
// CLOCK_RATE=8, BAUD_RATE=2 (4 cycles/bit) for the longer sequences.

module tb_uart_tx;

   localparam int DA = 1085;
   localparam int DB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a, vld_a, rdy_a, txd_a, busy_a;
   logic [7:0] data_a;
   logic       rst_b, vld_b, rdy_b, txd_b, busy_b;
   logic [7:0] data_b;

   uart_tx u_a (
      .clk_tx       (clk),
      .rst_n_clk_tx (rst_a),
      .tx_data      (data_a),
      .tx_data_vld  (vld_a),
      .tx_data_rdy  (rdy_a),
      .txd_tx       (txd_a),
      .tx_busy      (busy_a)
   );

   uart_tx #(.CLOCK_RATE(8), .BAUD_RATE(2)) u_b (
      .clk_tx       (clk),
      .rst_n_clk_tx (rst_b),
      .tx_data      (data_b),
      .tx_data_vld  (vld_b),
      .tx_data_rdy  (rdy_b),
      .txd_tx       (txd_b),
      .tx_busy      (busy_b)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
   endtask

   function automatic logic txd_of(input bit sel);
      return sel ? txd_b : txd_a;
   endfunction

   function automatic logic rdy_of(input bit sel);
      return sel ? rdy_b : rdy_a;
   endfunction

   function automatic logic busy_of(input bit sel);
      return sel ? busy_b : busy_a;
   endfunction

   task automatic drive(input bit sel, input logic [7:0] d, input logic v);
      if (sel) begin
         data_b = d;
         vld_b  = v;
      end else begin
         data_a = d;
         vld_a  = v;
      end
   endtask

   // Hands one byte over, then scrambles tx_data and checks the two-edge
   // start latency. Returns on the first negedge of the start bit.
   task automatic send(input bit sel, input logic [7:0] d, input string tag);
      int n;
      drive(sel, d, 1'b1);
      n = 0;
      while (!rdy_of(sel) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) chk($sformatf("%s_rdy_timeout", tag), 0, 1);
      @(posedge clk);
      @(negedge clk);
      drive(sel, ~d, 1'b0);
      chk($sformatf("%s_lat1", tag), txd_of(sel), 1);
      @(negedge clk);
      chk($sformatf("%s_lat2", tag), txd_of(sel), 1);
      @(negedge clk);
      chk($sformatf("%s_start", tag), txd_of(sel), 0);
   endtask

   // Checks every cycle of one frame against the expected bit; also counts
   // cycles during the frame where rdy was high.
   task automatic capture(input bit sel, input logic [7:0] d, input logic par,
                          input string tag, output int rdy_hi);
      int   dv;
      int   errs;
      logic e;
      dv     = sel ? DB : DA;
      rdy_hi = 0;
      for (int k = 0; k < NB; k++) begin
         if (k == 0)           e = 1'b0;
         else if (k <= 8)      e = d[k-1];
         else if (k == NB - 1) e = 1'b1;
         else                  e = par;
         errs = 0;
         repeat (dv) begin
            if (txd_of(sel) !== e) errs++;
            if (rdy_of(sel)) rdy_hi++;
            @(negedge clk);
         end
         chk($sformatf("%s_bit%0d", tag, k), errs, 0);
      end
   endtask

   task automatic chk_idle(input bit sel, input string tag);
      chk($sformatf("%s_idle_txd", tag), txd_of(sel), 1);
      chk($sformatf("%s_idle_busy", tag), busy_of(sel), 0);
      chk($sformatf("%s_idle_rdy", tag), rdy_of(sel), 1);
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int rh;
      int errs;

      rst_a = 1'b0;
      rst_b = 1'b0;
      drive(0, 8'h55, 1'b1);
      drive(1, 8'h55, 1'b1);
      repeat (5) @(negedge clk);
      chk("rst_txd_a", txd_a, 1);
      chk("rst_rdy_a", rdy_a, 1);
      chk("rst_busy_a", busy_a, 0);
      chk("rst_txd_b", txd_b, 1);
      chk("rst_busy_b", busy_b, 0);
      drive(0, 8'h55, 1'b0);
      drive(1, 8'h55, 1'b0);
      rst_a = 1'b1;
      rst_b = 1'b1;
      errs = 0;
      repeat (20) begin
         @(negedge clk);
         if (txd_a !== 1'b1 || busy_a !== 1'b0) errs++;
      end
      chk("post_rst_quiet", errs, 0);

      // 0xA5 at default rate: line 0,1,0,1,0,0,1,0,1,1
      send(0, 8'hA5, "a5");
      capture(0, 8'hA5, 1'b0, "a5", rh);
      chk_idle(0, "a5");

      // Back-to-back: 0x00, 0xFF held, then 0x3C stalled
      drive(1, 8'h00, 1'b1);
      @(posedge clk);
      @(negedge clk);
      chk("b2b_rdy_after_wr", rdy_b, 0);
      drive(1, 8'hFF, 1'b1);
      @(negedge clk);
      chk("b2b_rdy_drained", rdy_b, 1);
      chk("b2b_txd_pre", txd_b, 1);
      @(negedge clk);
      chk("b2b_rdy_ff_wr", rdy_b, 0);
      chk("b2b_start0", txd_b, 0);
      drive(1, 8'h3C, 1'b1);
      capture(1, 8'h00, 1'b0, "b2b0", rh);
      chk("b2b0_rdy_hi", rh, 1);
      drive(1, 8'h99, 1'b0);
      capture(1, 8'hFF, 1'b0, "b2b1", rh);
      chk("b2b1_rdy_hi", rh, 1);
      capture(1, 8'h3C, 1'b0, "b2b2", rh);
      chk("b2b2_rdy_hi", rh, NB * DB);
      chk_idle(1, "b2b");

      // tx_data changes right after acceptance
      send(1, 8'h5A, "stab");
      capture(1, 8'h5A, 1'b0, "stab", rh);
      chk_idle(1, "stab");

      // Reset during D3 with the holding register full
      send(1, 8'h00, "mrst");
      drive(1, 8'hFF, 1'b1);
      @(negedge clk);
      drive(1, 8'hFF, 1'b0);
      chk("mrst_rdy_full", rdy_b, 0);
      chk("mrst_busy", busy_b, 1);
      repeat (16) @(negedge clk);
      chk("mrst_d3", txd_b, 0);
      rst_b = 1'b0;
      @(negedge clk);
      chk("mrst_txd", txd_b, 1);
      chk("mrst_rdy", rdy_b, 1);
      chk("mrst_busy0", busy_b, 0);
      rst_b = 1'b1;
      errs = 0;
      repeat (60) begin
         @(negedge clk);
         if (txd_b !== 1'b1 || busy_b !== 1'b0) errs++;
      end
      chk("mrst_no_resume", errs, 0);

`ifdef UART_TX_PARITY_EN
      send(1, 8'h07, "par07");
      capture(1, 8'h07, 1'b1, "par07", rh);
      chk_idle(1, "par07");
      send(1, 8'h03, "par03");
      capture(1, 8'h03, 1'b0, "par03", rh);
      chk_idle(1, "par03");
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter. It is the transmit-side counterpart of the existing UART receive path, in the same clock domain family. It accepts bytes over a valid/ready handshake and serialises them on a single TXD line: 8N1 by default, with an optional even-parity bit. A one-entry holding register allows the next byte to be accepted while the current frame is still on the line, so consecutive frames go out with no idle gap.

## Interface
- CLOCK_RATE, 125_000_000, frequency of clk_tx in Hz
- BAUD_RATE, 115_200, line bit rate
- clk_tx  in  1  transmit clock; all logic on rising edge
- rst_n_clk_tx  in  1  synchronous, active-low reset, already synchronised to clk_tx
- tx_data  in  8  byte to send
- tx_data_vld  in  1  tx_data is valid
- tx_data_rdy  out  1  holding register empty; transfer occurs when vld && rdy at a clock edge
- txd_tx  out  1  serial output, idle high, registered
- tx_busy  out  1  frame in progress or holding register full

## Operation
- BAUD_DIV = CLOCK_RATE/BAUD_RATE, rounded to nearest; 1085 at defaults. Must be ≥ 2; elaborate-time error otherwise.
- Baud counter runs 0..BAUD_DIV-1. It restarts at 0 on every state entry, and each bit lasts exactly BAUD_DIV cycles.
- FSM states: IDLE, START, DATA, PARITY (only with macro), STOP.
  - IDLE: txd=1. If the holding register is full, load the shift register from it, clear the holding register and go to START.
  - START: txd=0 for one bit time, then go to DATA with bit index 0.
  - DATA: txd=shift[bit_idx], LSB first, for bit_idx 0..7.
    - After bit 7, go to PARITY if enabled, otherwise STOP.
  - STOP: txd=1 for one bit time. On the last cycle:
    - holding register full: load it and go directly to START (back-to-back frame).
    - holding register empty: go to IDLE.
- Holding register: written when tx_data_vld && tx_data_rdy.
  - tx_data_rdy = !hold_full, registered.
  - rdy falls the cycle after a write and rises the cycle after the FSM drains the register.
  - A write and a drain cannot coincide, because a write requires empty and a drain requires full.
- tx_data is sampled only on the accepting edge; later changes have no effect on that byte.
- tx_busy = (state != IDLE) || hold_full.
- No error outputs. Bytes are never dropped while rdy is honoured.

## Timing
- Reset values: txd_tx=1, tx_data_rdy=1, tx_busy=0. State is IDLE, holding register empty, counters 0. tx_data_vld is ignored while reset is asserted.
- Reset mid-frame: txd_tx returns to 1 at the reset edge. The holding register is discarded and no partial frame resumes.
- Latency:
  - From IDLE: byte accepted at edge N; FSM enters START at N+1; txd_tx goes low at edge N+2.
- Frame length: 10×BAUD_DIV cycles, or 11×BAUD_DIV with parity.
  - Back-to-back frames: the next start bit begins immediately after the last stop-bit cycle.
- vld held high with rdy low: nothing is accepted; the byte transfers on the first edge where rdy=1.

## Configuration
- UART_TX_PARITY_EN defined: PARITY state inserted after D7, txd = ^shift[7:0] (even parity). Frame is 11 bits.
- Undefined: no PARITY state or parity logic. Frame is 10 bits (8N1).

## Test plan
- Reset: hold rst_n_clk_tx=0 for 5 cycles with vld=1 -> txd_tx=1, rdy=1, busy=0. No frame starts after release until a new vld.
- Single byte 0xA5 at defaults -> txd sequence 0,1,0,1,0,0,1,0,1,1, each bit exactly 1085 cycles. Start bit falls 2 edges after acceptance.
- Back-to-back: send 0x00, then hold vld with 0xFF -> 0xFF accepted the cycle after 0x00 leaves the holding register, and rdy=0 until the first frame ends. Third byte 0x3C is stalled. Frames are contiguous with no idle bit, total 20×1085 cycles.
- Reset asserted during DATA bit 3 with the holding register full -> txd=1 at the reset edge, rdy=1, busy=0. No further frames follow.
- With UART_TX_PARITY_EN and BAUD_DIV=4: 0x07 -> parity bit 1; 0x03 -> parity bit 0. Frames are 44 cycles each.
- Data stability: change tx_data the cycle after acceptance of 0x5A -> transmitted bits still encode 0x5A.
